// File: rtl/cpu_pkg.sv
// Shared CPU types: condition codes, NZCV bit positions, memory FSM state
// and the MEM/WB pipeline bundle.
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        pcsrc;
    logic        regwrite;
    logic        memtoreg;
    logic        memerr;
    logic [31:0] readdata;
    logic [31:0] aluout;
    logic [31:0] pc;
    logic [3:0]  wa3;
  } mem_wb_t;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the architectural NZCV flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] CondM,
  input  logic [3:0] Flags,
  output logic       CondExM
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondExM = 1'b0;
    unique case (cond_t'(CondM))
      EQ: CondExM = z;
      NE: CondExM = ~z;
      CS: CondExM = c;
      CC: CondExM = ~c;
      MI: CondExM = n;
      PL: CondExM = ~n;
      VS: CondExM = v;
      VC: CondExM = ~v;
      HI: CondExM = c & ~z;
      LS: CondExM = ~c | z;
      GE: CondExM = (n == v);
      LT: CondExM = (n != v);
      GT: CondExM = ~z & (n == v);
      LE: CondExM = z | (n != v);
      AL: CondExM = 1'b1;
      NV: CondExM = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access stage with bounded-wait data memory handshake
// and the MEM/WB segment plus architectural flags register.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        FlagsWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCM,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  CondM,
  input  logic [3:0]  ALUFlagsM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic [3:0]  Flags,
  output logic        CondExM,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        MemErrW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [31:0] PCW,
  output logic [3:0]  WA3W
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    flags_q, flags_d;
  mem_wb_t       w_q, w_d;

  logic busy, ack, timeout, access, retire;

  cond_check u_cond (
    .CondM   (CondM),
    .Flags   (flags_q),
    .CondExM (CondExM)
  );

  assign busy    = (state_q == BUSY);
  assign ack     = busy & dmem_ack;
  assign timeout = busy & ~dmem_ack
                 & (cnt_q == CW'(MAX_WAIT - 1));
  assign access  = (MemtoRegM | MemWriteM) & CondExM;
  assign retire  = ~access | ack | timeout;

  assign StallM     = ~retire;
  assign dmem_req   = busy;
  assign dmem_we    = busy & MemWriteM;
  assign dmem_addr  = ALUOutM;
  assign dmem_wdata = WriteDataM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (dmem_ack | timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_d     = w_q;
    flags_d = flags_q;
    if (retire) begin
      w_d.pcsrc    = PCSrcM & CondExM;
      w_d.regwrite = RegWriteM & CondExM & ~timeout;
      w_d.memtoreg = MemtoRegM;
      w_d.memerr   = timeout;
      w_d.readdata = ack ? dmem_rdata : 32'h0;
      w_d.aluout   = ALUOutM;
      w_d.pc       = PCM;
      w_d.wa3      = WA3M;
      if (FlagsWriteM & CondExM) flags_d = ALUFlagsM;
    end else begin
      // bubble: kill controls, leave data as-is
      w_d.pcsrc    = 1'b0;
      w_d.regwrite = 1'b0;
      w_d.memtoreg = 1'b0;
      w_d.memerr   = 1'b0;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flags_q <= 4'b0000;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      w_q     <= w_d;
    end
  end

  assign Flags     = flags_q;
  assign PCSrcW    = w_q.pcsrc;
  assign RegWriteW = w_q.regwrite;
  assign MemtoRegW = w_q.memtoreg;
  assign MemErrW   = w_q.memerr;
  assign ReadDataW = w_q.readdata;
  assign ALUOutW   = w_q.aluout;
  assign PCW       = w_q.pc;
  assign WA3W      = w_q.wa3;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: condition table, directed
// memory corner cases and randomized instruction stream.
module tb_mem_wb_stage;

  localparam int MAX_WAIT = 15;

  logic        clk;
  logic        rst;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM;
  logic [31:0] ALUOutM, WriteDataM, PCM;
  logic [3:0]  WA3M, CondM, ALUFlagsM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        StallM;
  logic [3:0]  Flags;
  logic        CondExM;
  logic        PCSrcW, RegWriteW, MemtoRegW, MemErrW;
  logic [31:0] ReadDataW, ALUOutW, PCW;
  logic [3:0]  WA3W;

  int ntot = 0;
  int nbad = 0;
  logic [3:0] mflags;

  mem_wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .FlagsWriteM(FlagsWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .PCM(PCM),
    .WA3M(WA3M), .CondM(CondM), .ALUFlagsM(ALUFlagsM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .StallM(StallM), .Flags(Flags), .CondExM(CondExM),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .MemErrW(MemErrW), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .PCW(PCW), .WA3W(WA3W)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] cd,
                                   input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One instruction held in M until it retires. ack_at: BUSY cycle
  // (1-based) that sees ack, 0 = never. spur: ack pulse in the first cycle.
  task automatic run_instr(
    input logic pcs, input logic rw, input logic mtr,
    input logic mw, input logic fw,
    input logic [31:0] alu, input logic [31:0] wd,
    input logic [31:0] pc, input logic [3:0] wa3,
    input logic [3:0] cd, input logic [3:0] af,
    input int ack_at, input logic spur, input logic [31:0] rdata);
    logic cx, acc, err, a;
    int cycles;
    cx  = cond_ok(cd, mflags);
    acc = (mtr || mw) && cx;
    err = 1'b0;
    if (!acc) cycles = 1;
    else if (ack_at >= 1 && ack_at <= MAX_WAIT) cycles = ack_at + 1;
    else begin cycles = MAX_WAIT + 1; err = 1'b1; end
    PCSrcM = pcs; RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
    FlagsWriteM = fw; ALUOutM = alu; WriteDataM = wd; PCM = pc;
    WA3M = wa3; CondM = cd; ALUFlagsM = af;
    for (int c = 0; c < cycles; c++) begin
      a = (acc && ack_at >= 1 && c == ack_at) || (spur && c == 0);
      dmem_ack = a;
      dmem_rdata = (a && c >= 1) ? rdata : $urandom;
      #1;
      if (c == 0) chk("condex", CondExM, cx);
      chk("stall", StallM, c != cycles - 1);
      chk("req", dmem_req, acc && c >= 1);
      chk("we", dmem_we, acc && c >= 1 && mw);
      if (acc && c >= 1) begin
        chk("addr", dmem_addr, alu);
        chk("wdata", dmem_wdata, wd);
      end
      @(negedge clk); #1;
      if (c != cycles - 1) begin
        chk("bub_rw", RegWriteW, 1'b0);
        chk("bub_m2r", MemtoRegW, 1'b0);
        chk("bub_pcs", PCSrcW, 1'b0);
        chk("bub_err", MemErrW, 1'b0);
        chk("bub_flags", Flags, mflags);
      end
    end
    dmem_ack = 1'b0;
    if (fw && cx) mflags = af;
    chk("PCSrcW", PCSrcW, pcs && cx);
    chk("RegWriteW", RegWriteW, rw && cx && !err);
    chk("MemtoRegW", MemtoRegW, mtr);
    chk("MemErrW", MemErrW, err);
    chk("ReadDataW", ReadDataW, (acc && !err) ? rdata : 32'h0);
    chk("ALUOutW", ALUOutW, alu);
    chk("PCW", PCW, pc);
    chk("WA3W", WA3W, wa3);
    chk("Flags", Flags, mflags);
  endtask

  typedef struct {
    logic [3:0] fl;
    logic [3:0] cd;
    logic       exp;
  } cvec_t;

  cvec_t tbl[19];

  initial begin
    rst = 1'b0;
    {PCSrcM, RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM} = '0;
    ALUOutM = '0; WriteDataM = '0; PCM = '0;
    WA3M = '0; CondM = 4'hE; ALUFlagsM = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    mflags = 4'b0000;

    tbl[0]  = '{4'b0100, 4'd0,  1'b1};
    tbl[1]  = '{4'b0100, 4'd1,  1'b0};
    tbl[2]  = '{4'b0000, 4'd0,  1'b0};
    tbl[3]  = '{4'b0010, 4'd8,  1'b1};
    tbl[4]  = '{4'b0110, 4'd8,  1'b0};
    tbl[5]  = '{4'b1000, 4'd10, 1'b0};
    tbl[6]  = '{4'b1001, 4'd10, 1'b1};
    tbl[7]  = '{4'b1000, 4'd11, 1'b1};
    tbl[8]  = '{4'b0000, 4'd12, 1'b1};
    tbl[9]  = '{4'b0100, 4'd13, 1'b1};
    tbl[10] = '{4'b0001, 4'd13, 1'b1};
    tbl[11] = '{4'b1111, 4'd15, 1'b0};
    tbl[12] = '{4'b0000, 4'd14, 1'b1};
    tbl[13] = '{4'b1000, 4'd4,  1'b1};
    tbl[14] = '{4'b0000, 4'd5,  1'b1};
    tbl[15] = '{4'b0001, 4'd6,  1'b1};
    tbl[16] = '{4'b0000, 4'd7,  1'b1};
    tbl[17] = '{4'b0010, 4'd3,  1'b0};
    tbl[18] = '{4'b0000, 4'd9,  1'b1};

    #1;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_rw", RegWriteW, 1'b0);
    chk("rst_rd", ReadDataW, 32'h0);
    chk("rst_pc", PCW, 32'h0);
    repeat (2) @(posedge clk);
    rst = 1'b1;
    @(negedge clk); #1;

    // Condition table: load flags with an ADD, then probe CondM
    foreach (tbl[i]) begin
      run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10 + i, 32'h0,
                32'h1000 + 4 * i, 4'(i), 4'hE, tbl[i].fl, 0, 1'b0, 32'h0);
      CondM = tbl[i].cd;
      #1;
      chk($sformatf("cond_tbl%0d", i), CondExM, tbl[i].exp);
    end

    // ADD setting Z, then EQ passes
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5, 32'h0,
              32'h2000, 4'd1, 4'hE, 4'b0100, 0, 1'b0, 32'h0);
    CondM = 4'h0; #1;
    chk("eq_after_add", CondExM, 1'b1);

    // LDR acked on third BUSY cycle
    run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,
              32'h2004, 4'd2, 4'hE, 4'h0, 3, 1'b0, 32'hDEADBEEF);

    // STR under NE with Z set: skipped
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h55,
              32'h2008, 4'd3, 4'h1, 4'b1111, 1, 1'b0, 32'h0);

    // LDR that never gets ack
    run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0,
              32'h200C, 4'd4, 4'hE, 4'h0, 0, 1'b0, 32'h1234);

    // Ack coinciding with the timeout count
    run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h304, 32'h0,
              32'h2010, 4'd5, 4'hE, 4'h0, MAX_WAIT, 1'b0, 32'hCAFE0001);

    // Stray ack while idle
    run_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0,
              32'h2014, 4'd6, 4'hE, 4'h0, 0, 1'b1, 32'h0);

    // Reset in the middle of a BUSY access
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 32'h0,
              32'h2018, 4'd7, 4'hE, 4'b1010, 0, 1'b0, 32'h0);
    PCSrcM = 1'b0; RegWriteM = 1'b1; MemtoRegM = 1'b1;
    MemWriteM = 1'b0; FlagsWriteM = 1'b0; CondM = 4'hE;
    ALUOutM = 32'h400; PCM = 32'h201C; WA3M = 4'd8;
    #1;
    @(negedge clk); #1;
    chk("pre_rst_req", dmem_req, 1'b1);
    rst = 1'b0; #1;
    chk("mid_rst_req", dmem_req, 1'b0);
    chk("mid_rst_we", dmem_we, 1'b0);
    chk("mid_rst_flags", Flags, 4'b0000);
    chk("mid_rst_alu", ALUOutW, 32'h0);
    chk("mid_rst_pc", PCW, 32'h0);
    chk("mid_rst_wa3", WA3W, 4'h0);
    chk("mid_rst_rw", RegWriteW, 1'b0);
    #1 rst = 1'b1;
    mflags = 4'b0000;
    run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0,
              32'h201C, 4'd8, 4'hE, 4'h0, 1, 1'b0, 32'hA5A5A5A5);

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      int r, aa;
      r = $urandom_range(0, 9);
      if (r < 7) aa = $urandom_range(1, 4);
      else if (r == 7) aa = 0;
      else aa = $urandom_range(1, MAX_WAIT);
      run_instr(1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom, 4'($urandom), 4'($urandom), 4'($urandom),
                aa, 1'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
